// File: rtl/mux_n_to_1_pipe.sv
// NUM_IN:1 WIDTH-bit mux with one registered output stage, valid/ready on both sides and a
// 2-entry skid buffer. Define MUX_SEL_CHECK_EN to zero out-of-range selects instead of wrapping.
module mux_n_to_1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        in_sel_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [SEL_W-1:0]        out_sel_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [CNT_W-1:0]        xfer_cnt_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  m_data_q, s_data_q;
  logic [SEL_W-1:0]  m_sel_q, s_sel_q;
  logic              out_valid_q, in_ready_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [WIDTH-1:0]  words [NUM_IN];
  logic [WIDTH-1:0]  mux_data;
  logic [SEL_W-1:0]  mux_sel;
  logic              accept, take;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign words[gi] = in_data_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef MUX_SEL_CHECK_EN
  logic sel_ok;
  assign sel_ok = (32'(in_sel_i) < NUM_IN);

  always_comb begin
    mux_data = '0;
    mux_sel  = in_sel_i;
    if (sel_ok) mux_data = words[in_sel_i];
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && accept && !sel_ok)
      $error("mux_n_to_1_pipe: out-of-range select %0d accepted", in_sel_i);
  end
`endif
`else
  logic [SEL_W-1:0] sel_mod;
  // Wrap the select so non-power-of-2 NUM_IN never indexes past the last input.
  assign sel_mod  = SEL_W'(32'(in_sel_i) % NUM_IN);
  assign mux_data = words[sel_mod];
  assign mux_sel  = sel_mod;
`endif

  assign accept = in_valid_i & in_ready_q;
  assign take   = out_valid_q & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      m_data_q    <= '0;
      m_sel_q     <= '0;
      s_data_q    <= '0;
      s_sel_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (accept) cnt_q <= cnt_q + 1'b1;
      case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            m_data_q    <= mux_data;
            m_sel_q     <= mux_sel;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && take) begin
            m_data_q <= mux_data;
            m_sel_q  <= mux_sel;
          end else if (accept) begin
            s_data_q   <= mux_data;
            s_sel_q    <= mux_sel;
            in_ready_q <= 1'b0;
            state_q    <= TWO;
          end else if (take) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            m_data_q   <= s_data_q;
            m_sel_q    <= s_sel_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = m_data_q;
  assign out_sel_o   = m_sel_q;
  assign out_valid_o = out_valid_q;
  assign xfer_cnt_o  = cnt_q;

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Directed self-checking bench for mux_n_to_1_pipe (4-input main instance, 3-input select-range instance).
module tb_mux_n_to_1_pipe;
  localparam logic [31:0] A = 32'h11111111;
  localparam logic [31:0] B = 32'h22222222;
  localparam logic [31:0] C = 32'h33333333;
  localparam logic [31:0] D = 32'h44444444;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [127:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic [15:0] xfer_cnt;

  logic [95:0] in_data3;
  logic [1:0]  in_sel3, out_sel3;
  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [31:0] out_data3;
  logic [15:0] xfer_cnt3;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  mux_n_to_1_pipe #(.WIDTH(32), .NUM_IN(4), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_sel_i(in_sel),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .out_data_o(out_data),
    .out_sel_o(out_sel), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .xfer_cnt_o(xfer_cnt)
  );

  mux_n_to_1_pipe #(.WIDTH(32), .NUM_IN(3), .CNT_W(16)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data3), .in_sel_i(in_sel3),
    .in_valid_i(in_valid3), .in_ready_o(in_ready3), .out_data_o(out_data3),
    .out_sel_o(out_sel3), .out_valid_o(out_valid3), .out_ready_i(out_ready3),
    .xfer_cnt_o(xfer_cnt3)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_low: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rel_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h0) $display("FAIL rel_out_data: got %h want 0", out_data); else pass_cnt++;
    total_cnt++; if (out_sel !== 2'd0) $display("FAIL rel_out_sel: got %0d want 0", out_sel); else pass_cnt++;
    total_cnt++; if (xfer_cnt !== 16'd0) $display("FAIL rel_xfer_cnt: got %0d want 0", xfer_cnt); else pass_cnt++;
    $display("reset: in_ready=%b out_valid=%b xfer_cnt=%0d", in_ready, out_valid, xfer_cnt);
  endtask

  task automatic test_single();
    in_data = {D, C, B, A}; in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_sel = 2'd1;
    exp_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== C) $display("FAIL single_data: got %h want %h", out_data, C); else pass_cnt++;
    total_cnt++; if (out_sel !== 2'd2) $display("FAIL single_sel: got %0d want 2", out_sel); else pass_cnt++;
    total_cnt++; if (xfer_cnt !== 16'(exp_cnt)) $display("FAIL single_cnt: got %0d want %0d", xfer_cnt, exp_cnt); else pass_cnt++;
    $display("single: sel=2 data=%h", out_data);
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_one_cycle: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    in_data = {D, C, B, A}; out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after1: got %b want 1", in_ready); else pass_cnt++;
    in_sel = 2'd1;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", in_ready); else pass_cnt++;
    in_sel = 2'd3;
    @(negedge clk);
    exp_cnt += 2;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_third_blocked: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (xfer_cnt !== 16'(exp_cnt)) $display("FAIL bp_cnt: got %0d want %0d", xfer_cnt, exp_cnt); else pass_cnt++;
    total_cnt++; if (out_data !== A || out_valid !== 1'b1) $display("FAIL bp_out_A: got %h/%b want %h/1", out_data, out_valid, A); else pass_cnt++;
    $display("bp: out=%h held", out_data);
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (out_data !== B || out_valid !== 1'b1) $display("FAIL bp_out_B: got %h/%b want %h/1", out_data, out_valid, B); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_reopen: got %b want 1", in_ready); else pass_cnt++;
    $display("bp: out=%h", out_data);
    @(negedge clk);
    in_valid = 1'b0;
    exp_cnt++;
    total_cnt++; if (out_data !== D || out_valid !== 1'b1 || out_sel !== 2'd3) $display("FAIL bp_out_D: got %h/%b/%0d want %h/1/3", out_data, out_valid, out_sel, D); else pass_cnt++;
    $display("bp: out=%h", out_data);
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (xfer_cnt !== 16'(exp_cnt)) $display("FAIL bp_cnt_end: got %0d want %0d", xfer_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_stream();
    int good = 0;
    logic [31:0] prev_exp = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) begin
        if (out_valid === 1'b1 && out_data === prev_exp && in_ready === 1'b1) good++;
      end
      for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = {16'(i), 16'(k)};
      in_sel = 2'(i % 4);
      in_valid = 1'b1;
      prev_exp = {16'(i), 16'(i % 4)};
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (out_valid === 1'b1 && out_data === prev_exp) good++;
    exp_cnt += 100;
    $display("stream: %0d words in order", good);
    total_cnt++; if (good != 100) $display("FAIL stream_words: got %0d want 100", good); else pass_cnt++;
    total_cnt++; if (xfer_cnt !== 16'(exp_cnt)) $display("FAIL stream_cnt: got %0d want %0d", xfer_cnt, exp_cnt); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_in_two();
    int stale = 0;
    in_data = {D, C, B, A}; out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd2;
    repeat (2) @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL two_reached: got rdy=%b vld=%b want 0/1", in_ready, out_valid); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL async_rst_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL async_rst_ready: got %b want 0", in_ready); else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    $display("reset_in_two: stale outputs=%0d", stale);
    total_cnt++; if (stale != 0) $display("FAIL no_stale: got %0d want 0", stale); else pass_cnt++;
    total_cnt++; if (xfer_cnt !== 16'd0) $display("FAIL rst2_cnt: got %0d want 0", xfer_cnt); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h0) $display("FAIL rst2_data: got %h want 0", out_data); else pass_cnt++;
  endtask

  task automatic test_sel_range();
    logic [31:0] exp_data;
    logic [1:0]  exp_sel;
`ifdef MUX_SEL_CHECK_EN
    exp_data = 32'h0; exp_sel = 2'd3;
`else
    exp_data = A; exp_sel = 2'd0;
`endif
    in_data3 = {C, B, A}; in_sel3 = 2'd3; in_valid3 = 1'b1;
    @(negedge clk);
    in_sel3 = 2'd2;
    total_cnt++; if (out_valid3 !== 1'b1 || out_data3 !== exp_data) $display("FAIL oob_data: got %h/%b want %h/1", out_data3, out_valid3, exp_data); else pass_cnt++;
    total_cnt++; if (out_sel3 !== exp_sel) $display("FAIL oob_sel: got %0d want %0d", out_sel3, exp_sel); else pass_cnt++;
    $display("sel_range: sel=3 data=%h", out_data3);
    @(negedge clk);
    in_valid3 = 1'b0;
    total_cnt++; if (out_data3 !== C || out_sel3 !== 2'd2) $display("FAIL n3_sel2: got %h/%0d want %h/2", out_data3, out_sel3, C); else pass_cnt++;
    total_cnt++; if (xfer_cnt3 !== 16'd2) $display("FAIL n3_cnt: got %0d want 2", xfer_cnt3); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data3 = '0; in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_reset_in_two();
    test_sel_range();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
